// File: rtl/compressor_pkg.sv
// Shared types and helpers for the carry-save reduction tree.
// Holds the majority function used by every compressor cell.
package compressor_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int MAX_WIDTH     = 64;

  // Result of one compressor row, sized for the widest legal row so tree
  // stages of different widths can pass it around without re-declaring it.
  typedef struct packed {
    logic [MAX_WIDTH-1:0] sum;
    logic [MAX_WIDTH-1:0] carry;
    logic                 cout;
  } cs_result_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/compressor_4_2_cell.sv
// One-bit 4:2 compressor cell, purely combinational.
// co depends only on x1..x3, so chaining co into the next ci never ripples.
module compressor_4_2_cell
  import compressor_pkg::*;
(
  input  logic x1,
  input  logic x2,
  input  logic x3,
  input  logic x4,
  input  logic ci,
  output logic s,
  output logic c,
  output logic co
);

  logic w_t;

  assign w_t = x1 ^ x2 ^ x3;
  assign co  = maj3(x1, x2, x3);
  assign s   = w_t ^ x4 ^ ci;
  assign c   = maj3(w_t, x4, ci);

endmodule

// File: rtl/compressor_4_2.sv
// Registered row of WIDTH 4:2 compressors; 1-cycle latency, no backpressure, holds on in_valid=0.
// Define COMPRESSOR_4_2_ASSERT_EN to compile in the row-invariant simulation checks.
module compressor_4_2
  import compressor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] x4,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry,
  output logic             cout
);

  logic [WIDTH:0]   w_chain;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_carry;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_carry;
  logic             r_cout;

  assign w_chain[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    compressor_4_2_cell u_cell (
      .x1 (x1[i]),
      .x2 (x2[i]),
      .x3 (x3[i]),
      .x4 (x4[i]),
      .ci (w_chain[i]),
      .s  (w_sum[i]),
      .c  (w_carry[i]),
      .co (w_chain[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_sum       <= '0;
      r_carry     <= '0;
      r_cout      <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum   <= w_sum;
        r_carry <= w_carry;
        r_cout  <= w_chain[WIDTH];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign carry     = r_carry;
  assign cout      = r_cout;

`ifdef COMPRESSOR_4_2_ASSERT_EN
  // Three extra bits cover 4*(2^WIDTH-1)+1 on both sides of the invariant.
  localparam int SW = WIDTH + 3;

  logic [WIDTH-1:0] r_x1_q;
  logic [WIDTH-1:0] r_x2_q;
  logic [WIDTH-1:0] r_x3_q;
  logic [WIDTH-1:0] r_x4_q;
  logic             r_cin_q;
  logic [SW-1:0]    w_lhs;
  logic [SW-1:0]    w_rhs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x1_q  <= '0;
      r_x2_q  <= '0;
      r_x3_q  <= '0;
      r_x4_q  <= '0;
      r_cin_q <= 1'b0;
    end else if (in_valid) begin
      r_x1_q  <= x1;
      r_x2_q  <= x2;
      r_x3_q  <= x3;
      r_x4_q  <= x4;
      r_cin_q <= cin;
    end
  end

  assign w_lhs = SW'(r_x1_q) + SW'(r_x2_q) + SW'(r_x3_q) + SW'(r_x4_q) + SW'(r_cin_q);
  assign w_rhs = SW'(r_sum) + (SW'(r_carry) << 1) + (SW'(r_cout) << WIDTH);

  a_row_invariant : assert property (@(posedge clk) disable iff (!rst_n)
    r_out_valid |-> (w_lhs == w_rhs))
    else $error("compressor_4_2 row invariant violated: lhs=%0d rhs=%0d", w_lhs, w_rhs);

  a_valid_known : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(r_out_valid))
    else $error("compressor_4_2 out_valid is unknown");
`else
  // Synthesis build: no shadow operands and no checkers.
`endif

endmodule

// File: tb/tb_compressor_4_2.sv
module tb_compressor_4_2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       v1, a1, b1, c1, d1, ci1, ov1, co1;
  logic [0:0] s1, k1;
  logic       v4, ci4, ov4, co4;
  logic [3:0] a4, b4, c4, d4, s4, k4;
  logic        v16, ci16, ov16, co16;
  logic [15:0] a16, b16, c16, d16, s16, k16;

  compressor_4_2 #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1),
    .x1(a1), .x2(b1), .x3(c1), .x4(d1), .cin(ci1),
    .out_valid(ov1), .sum(s1), .carry(k1), .cout(co1));

  compressor_4_2 #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(v4),
    .x1(a4), .x2(b4), .x3(c4), .x4(d4), .cin(ci4),
    .out_valid(ov4), .sum(s4), .carry(k4), .cout(co4));

  compressor_4_2 #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16),
    .x1(a16), .x2(b16), .x3(c16), .x4(d16), .cin(ci16),
    .out_valid(ov16), .sum(s16), .carry(k16), .cout(co16));

  typedef struct {
    logic [4:0] ins;   // {x1,x2,x3,x4,cin}
    logic [2:0] outs;  // {sum,carry,cout}
  } vec_t;

  vec_t tbl[36];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] w16_value();
    return 64'(s16) + (64'(k16) << 1) + (64'(co16) << 16);
  endfunction

  initial begin
    logic [63:0] model_tot;
    logic [63:0] pend_tot;
    logic        model_v;
    logic [3:0]  held_s, held_k;
    logic        held_co;

    // Literal examples first, then all 32 combinations from arithmetic.
    tbl[0] = '{5'b11111, 3'b111};
    tbl[1] = '{5'b00000, 3'b000};
    tbl[2] = '{5'b10000, 3'b100};
    tbl[3] = '{5'b11000, 3'b001};
    for (int i = 0; i < 32; i++) begin
      int x1b, x2b, x3b, x4b, cb, tot, sb, cob, kb;
      x1b = (i >> 4) & 1; x2b = (i >> 3) & 1; x3b = (i >> 2) & 1;
      x4b = (i >> 1) & 1; cb = i & 1;
      tot = x1b + x2b + x3b + x4b + cb;
      sb  = tot % 2;
      cob = (x1b + x2b + x3b >= 2) ? 1 : 0;
      kb  = (tot - sb) / 2 - cob;
      tbl[4+i].ins  = 5'(i);
      tbl[4+i].outs = {sb[0], kb[0], cob[0]};
    end

    v1 = 0; a1 = 0; b1 = 0; c1 = 0; d1 = 0; ci1 = 0;
    v4 = 0; a4 = 0; b4 = 0; c4 = 0; d4 = 0; ci4 = 0;
    v16 = 0; a16 = 0; b16 = 0; c16 = 0; d16 = 0; ci16 = 0;

    #12;
    check("reset_ov1", 64'(ov1), 64'd0);
    check("reset_w1", 64'({s1, k1, co1}), 64'd0);
    check("reset_ov4", 64'(ov4), 64'd0);
    check("reset_ov16", 64'(ov16), 64'd0);
    check("reset_w16", w16_value(), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 table
    for (int i = 0; i < 36; i++) begin
      {a1, b1, c1, d1, ci1} = tbl[i].ins;
      v1 = 1'b1;
      tick();
      check($sformatf("w1_vec%0d_%b", i, tbl[i].ins), 64'({s1, k1, co1}), 64'(tbl[i].outs));
      check($sformatf("w1_ov%0d", i), 64'(ov1), 64'd1);
    end
    v1 = 1'b0;

    // WIDTH=4 all-ones, then hold
    a4 = 4'hF; b4 = 4'hF; c4 = 4'hF; d4 = 4'hF; ci4 = 1'b1; v4 = 1'b1;
    tick();
    check("w4_ones_sum", 64'(s4), 64'hF);
    check("w4_ones_carry", 64'(k4), 64'hF);
    check("w4_ones_cout", 64'(co4), 64'd1);
    check("w4_ones_ov", 64'(ov4), 64'd1);
    held_s = 4'hF; held_k = 4'hF; held_co = 1'b1;
    v4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom);
      d4 = 4'($urandom); ci4 = 1'($urandom);
      tick();
      check($sformatf("w4_hold%0d", i), 64'({s4, k4, co4}), 64'({held_s, held_k, held_co}));
      check($sformatf("w4_hold_ov%0d", i), 64'(ov4), 64'd0);
    end

    // WIDTH=16 random stream against an arithmetic model of the row value
    model_tot = 64'd0;
    for (int n = 0; n < 10000; n++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); c16 = 16'($urandom);
      d16 = 16'($urandom); ci16 = 1'($urandom);
      v16 = ($urandom_range(0, 9) != 0);
      pend_tot = 64'(a16) + 64'(b16) + 64'(c16) + 64'(d16) + 64'(ci16);
      model_v = v16;
      if (v16) model_tot = pend_tot;
      tick();
      check($sformatf("w16_ov%0d", n), 64'(ov16), 64'(model_v));
      check($sformatf("w16_row%0d", n), w16_value(), model_tot);
    end

    // Reset mid-stream between edges, with a valid transfer in flight
    a16 = 16'h1234; b16 = 16'hFFFF; c16 = 16'h8000; d16 = 16'h0F0F; ci16 = 1'b1; v16 = 1'b1;
    tick();
    check("w16_pre_reset", w16_value(), 64'h1234 + 64'hFFFF + 64'h8000 + 64'h0F0F + 64'd1);
    a16 = 16'hAAAA; v4 = 1'b1;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_ov16", 64'(ov16), 64'd0);
    check("rst_async_w16", 64'({s16, k16, co16}), 64'd0);
    check("rst_async_w4", 64'({ov4, s4, k4, co4}), 64'd0);
    tick();
    check("rst_hold_w16", 64'({ov16, s16, k16, co16}), 64'd0);
    #2;
    rst_n = 1'b1;
    a16 = 16'd1; b16 = 16'd0; c16 = 16'd0; d16 = 16'd0; ci16 = 1'b0; v16 = 1'b1;
    v4 = 1'b0;
    tick();
    check("post_rst_sum", 64'(s16), 64'd1);
    check("post_rst_carry", 64'(k16), 64'd0);
    check("post_rst_cout", 64'(co16), 64'd0);
    check("post_rst_ov", 64'(ov16), 64'd1);
    v16 = 1'b0;
    tick();
    check("post_rst_ov_drop", 64'(ov16), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
